// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and line idle level.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    // Level of an idle (marking) line; the TX side drives the same value between frames.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer for the UART receiver. After restart it fires sample_tick
// half a bit later (middle of the start bit), then once per full bit period,
// so every tick lands in the middle of a bit cell.
module uart_rx_bit_timer #(
    parameter  int CLKS_PER_BIT = 16,
    localparam int TW           = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic sample_tick
);

    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;
    logic          half;

    assign sample_tick = run && (cnt == (half ? HALF_LAST : FULL_LAST));

    // Count clocks; wrap to zero on every tick and switch to full-period spacing after the first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            half <= 1'b1;
        end else if (restart) begin
            cnt  <= '0;
            half <= 1'b1;
        end else if (run) begin
            if (sample_tick) begin
                cnt  <= '0;
                half <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_block.sv
// UART receiver: 8N1, LSB first. Synchronizes the line, validates the start
// bit at mid-bit, shifts in eight data bits, checks the stop bit and hands the
// byte to the packet logic through a level-held byte_ready / read_byte pair.
module uart_rx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_in,
    input  logic                      read_byte,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      byte_ready,
    output logic                      framing_error,
    output logic                      overrun,
    output logic                      rx_busy
);

    logic [1:0]                sync;
    logic                      rx_s;
    logic                      line_idle;
    rx_state_e                 state;
    logic [3:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      tick;
    logic                      restart;
    logic                      run;
    logic                      commit;

    assign rx_s      = sync[1];
    assign line_idle = (rx_s == UART_IDLE_LEVEL);
    assign restart   = (state == RX_IDLE) && !line_idle;
    assign run       = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);
    assign commit    = (state == RX_STOP) && tick && line_idle;
    assign rx_busy   = (state != RX_IDLE);

    // Two-flop synchronizer; resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= {2{UART_IDLE_LEVEL}};
        else        sync <= {sync[0], serial_in};
    end

    uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .run         (run),
        .sample_tick (tick)
    );

    // Frame controller: start validation, data shift, stop check, break recovery.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RX_IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!line_idle) begin
                        state   <= RX_START;
                        bit_cnt <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is gone by mid-bit was a glitch.
                    if (tick) state <= line_idle ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(UART_DATA_BITS - 1)) state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leaving at mid-stop-bit keeps us ready for a back-to-back start edge.
                    if (tick) begin
                        if (line_idle) begin
                            state <= RX_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= RX_WAIT_IDLE;
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    if (line_idle) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // Holding register: load on commit if free (or freed this cycle), else flag the lost byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            byte_ready <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            if (!byte_ready || read_byte) begin
                data_out   <= shreg;
                byte_ready <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (read_byte && byte_ready) begin
            byte_ready <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_block.sv
// Self-checking bench for uart_rx_block: reset state, a vector table of frames,
// hand-written corner sequences and a randomized frame stream against a
// transaction-level model of the receive holding register.
module tb_uart_rx_block;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       read_byte;
    logic [7:0] data_out;
    logic       byte_ready;
    logic       framing_error;
    logic       overrun;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx_block #(.CLKS_PER_BIT(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .read_byte     (read_byte),
        .data_out      (data_out),
        .byte_ready    (byte_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .rx_busy       (rx_busy)
    );

    int   cyc = 0;
    int   rise_cyc = -1;
    int   ferr_cnt = 0;
    logic prev_rdy = 1'b0;

    always @(posedge clk) cyc++;

    // Observe rising edge of byte_ready and count framing_error cycles.
    always @(negedge clk) begin
        if (byte_ready && !prev_rdy) rise_cyc = cyc;
        prev_rdy = byte_ready;
        if (framing_error) ferr_cnt++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    int frame_start;

    // Drive a frame (start, 8 data LSB first, stop) for ncyc clocks; pulse read_byte at offset read_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ncyc, input int read_at);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) frame_start = cyc;
            serial_in = bits[k / N];
            read_byte = (k == read_at);
        end
        read_byte = 1'b0;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        @(negedge clk);
        read_byte = 1'b1;
        @(negedge clk);
        read_byte = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];
    int   f0;

    // Transaction-level model state for the random stream.
    logic       m_have;
    logic [7:0] m_held;
    logic       m_ovr;
    int         m_ferr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
        vecs[3] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 8'h00, 1'b1};

        reset     = 1'b0;
        serial_in = 1'b1;
        read_byte = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset data_out", 32'(data_out), 32'h00);
        chk("reset byte_ready", 32'(byte_ready), 32'h0);
        chk("reset framing_error", 32'(framing_error), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        chk("reset rx_busy", 32'(rx_busy), 32'h0);
        reset = 1'b1;
        idle(4);

        // 8'hA5: line falls at offset 0, rx_s low (t0) at offset 2, byte_ready at t0+153.
        f0 = ferr_cnt;
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 10 * N, -1);
        @(negedge clk);
        chk("A5 latency", 32'(rise_cyc - frame_start), 32'd155);
        chk("A5 data", 32'(data_out), 32'hA5);
        chk("A5 ready", 32'(byte_ready), 32'h1);
        chk("A5 overrun", 32'(overrun), 32'h0);
        chk("A5 ferr", 32'(ferr_cnt - f0), 32'd0);
        do_read();
        chk("A5 ready after read", 32'(byte_ready), 32'h0);
        idle(3);

        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 10 * N, -1);
            @(negedge clk);
            if (!vecs[i].stop) serial_in = 1'b1;
            chk($sformatf("vec%0d ready", i), 32'(byte_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_ready) chk($sformatf("vec%0d data", i), 32'(data_out), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            if (vecs[i].exp_ready) do_read();
            idle(4);
        end

        // 5-cycle low glitch: busy from offset 3 through the start sample at offset 10.
        f0 = ferr_cnt;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2)  chk("glitch busy@2", 32'(rx_busy), 32'h0);
            if (k == 3)  chk("glitch busy@3", 32'(rx_busy), 32'h1);
            if (k == 10) chk("glitch busy@10", 32'(rx_busy), 32'h1);
            if (k == 11) chk("glitch busy@11", 32'(rx_busy), 32'h0);
            serial_in = (k >= 5);
        end
        chk("glitch ready", 32'(byte_ready), 32'h0);
        chk("glitch ferr", 32'(ferr_cnt - f0), 32'd0);

        // Bad stop bit followed by a held-low line, then recovery with 8'h81.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 10 * N, -1);
        repeat (40) @(negedge clk);
        chk("break ferr pulses", 32'(ferr_cnt - f0), 32'd1);
        chk("break ready", 32'(byte_ready), 32'h0);
        chk("break busy", 32'(rx_busy), 32'h1);
        idle(4);
        chk("break recovered", 32'(rx_busy), 32'h0);
        send_frame(8'h81, 1'b1, 10 * N, -1);
        @(negedge clk);
        chk("81 ready", 32'(byte_ready), 32'h1);
        chk("81 data", 32'(data_out), 32'h81);
        chk("81 ferr", 32'(ferr_cnt - f0), 32'd1);
        do_read();
        idle(3);

        // Back-to-back without read: second byte lost.
        send_frame(8'h11, 1'b1, 10 * N, -1);
        send_frame(8'h22, 1'b1, 10 * N, -1);
        @(negedge clk);
        chk("ovr data", 32'(data_out), 32'h11);
        chk("ovr ready", 32'(byte_ready), 32'h1);
        chk("ovr flag", 32'(overrun), 32'h1);
        do_read();
        chk("ovr ready cleared", 32'(byte_ready), 32'h0);
        chk("ovr flag cleared", 32'(overrun), 32'h0);
        idle(3);

        // Read of 8'h11 in the very cycle 8'h22 commits (stop sample at offset 154).
        send_frame(8'h11, 1'b1, 10 * N, -1);
        send_frame(8'h22, 1'b1, 10 * N, 154);
        @(negedge clk);
        chk("coinc data", 32'(data_out), 32'h22);
        chk("coinc ready", 32'(byte_ready), 32'h1);
        chk("coinc overrun", 32'(overrun), 32'h0);

        // Reset in the middle of data bit 4 of 8'hFF.
        send_frame(8'hFF, 1'b1, 5 * N + N / 2, -1);
        chk("pre-reset busy", 32'(rx_busy), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid reset data", 32'(data_out), 32'h00);
        chk("mid reset ready", 32'(byte_ready), 32'h0);
        chk("mid reset overrun", 32'(overrun), 32'h0);
        chk("mid reset ferr", 32'(framing_error), 32'h0);
        chk("mid reset busy", 32'(rx_busy), 32'h0);
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(4);
        chk("post reset busy", 32'(rx_busy), 32'h0);
        send_frame(8'h5A, 1'b1, 10 * N, -1);
        @(negedge clk);
        chk("5A ready", 32'(byte_ready), 32'h1);
        chk("5A data", 32'(data_out), 32'h5A);
        chk("5A overrun", 32'(overrun), 32'h0);
        do_read();
        idle(3);

        // Random frames, optional bad stop bits and skipped reads, against the model.
        m_have = 1'b0;
        m_held = 8'h5A;
        m_ovr  = 1'b0;
        m_ferr = 0;
        f0     = ferr_cnt;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       stop_ok;
            logic       rd;
            d       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 4) != 0);
            rd      = ($urandom_range(0, 2) != 0);
            send_frame(d, stop_ok, 10 * N, -1);
            @(negedge clk);
            if (!stop_ok) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                serial_in = 1'b1;
                m_ferr++;
            end else if (!m_have) begin
                m_have = 1'b1;
                m_held = d;
            end else begin
                m_ovr = 1'b1;
            end
            chk($sformatf("rnd%0d ready", i), 32'(byte_ready), 32'(m_have));
            chk($sformatf("rnd%0d data", i), 32'(data_out), 32'(m_held));
            chk($sformatf("rnd%0d overrun", i), 32'(overrun), 32'(m_ovr));
            chk($sformatf("rnd%0d ferr", i), 32'(ferr_cnt - f0), 32'(m_ferr));
            if (rd) begin
                do_read();
                if (m_have) begin
                    m_have = 1'b0;
                    m_ovr  = 1'b0;
                end
            end
            idle($urandom_range(3, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_block.md
# uart_rx_block

Serial receiver for the router's UART link, sitting directly downstream of the UART transmit block and consuming its `serial_out` line (8 data bits, LSB first, 1 start, 1 stop, no parity). It synchronizes the asynchronous line and detects and validates the start bit. It samples each bit at mid-period, checks the stop bit, and presents the assembled byte through a level-held ready/read handshake to the packet logic.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; even, ≥ 4.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state when 0.
- `serial_in` input 1: asynchronous serial line, idle high.
- `read_byte` input 1: one-cycle pulse; consumer has taken `data_out`.
- `data_out` output 8: last received byte; reset 8'h00.
- `byte_ready` output 1: valid unread byte in `data_out`; reset 0.
- `framing_error` output 1: one-cycle pulse, stop bit sampled low; reset 0.
- `overrun` output 1: sticky, a byte was lost; reset 0.
- `rx_busy` output 1: state ≠ IDLE; reset 0.

## Operation
- Input path: 2-flop synchronizer, reset value 1. All logic uses the synchronized line `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: `rx_s`=0 → START, bit counter cleared, timer cleared.
- START: after CLKS_PER_BIT/2 cycles, sample `rx_s`.
  - 0 → DATA, timer restarts.
  - 1 → IDLE (glitch rejected, no output activity).
- DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift register, LSB first. After 8th sample → STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - 1 → byte commit, → IDLE.
  - 0 → `framing_error` pulse, byte discarded, → WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1 (break/stuck-low line), then → IDLE.
- Byte commit with `byte_ready`=0: `data_out` ← shift register, `byte_ready` ← 1.
- Byte commit with `byte_ready`=1 and no `read_byte`: `data_out` unchanged (old byte kept), new byte dropped, `overrun` ← 1.
- Commit and `read_byte` in the same cycle: new byte loaded, `byte_ready` stays 1, no overrun.
- `read_byte` with `byte_ready`=1 (no commit): `byte_ready` ← 0 next cycle, and `overrun` ← 0.
- `read_byte` with `byte_ready`=0: ignored.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values. A partially received frame is lost. A reset released while the line is low starts a frame on the first low sample.

## Timing
- t0 = first cycle `rx_s`=0 in IDLE. `serial_in` to `rx_s` latency is 2 cycles.
- Start sample at t0 + CLKS_PER_BIT/2.
- Data bit k (0..7) sampled at t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `byte_ready`/`data_out`/`framing_error` registered, valid the cycle after the stop sample. With default 16: 153 cycles after t0.
- Back-to-back frames: IDLE is re-entered half a bit before the nominal stop end, so the next start edge is always caught.
- Timer width: ceil(log2(CLKS_PER_BIT)) bits. Bit counter: 4 bits.
- Timer wraps to 0 on each sample. Counter is never compared beyond 8.

## Structure
- Package `uart_pkg`:
  - rx state enum.
  - `UART_DATA_BITS` = 8.
  - Idle line level constant, shared with the TX side.
- Sub-module `uart_rx_bit_timer`: counts clk cycles.
  - Issues a one-cycle `sample_tick` at half period after `restart`, then every full period.
  - Controller FSM, shift register and holding register stay in `uart_rx_block`.

## Test plan
- Send 8'hA5 at CLKS_PER_BIT=16 → `byte_ready` rises exactly 153 cycles after t0, `data_out`=8'hA5, `framing_error`/`overrun` stay 0. Pulse `read_byte` → `byte_ready`=0 next cycle.
- Low glitch of 5 cycles on idle line → returns to IDLE at start sample, no `byte_ready`, `rx_busy` drops after CLKS_PER_BIT/2.
- Frame 8'h3C with stop bit forced 0, line held low 40 more cycles → one `framing_error` pulse, `byte_ready`=0, stays in WAIT_IDLE until line high, then next frame 8'h81 received correctly.
- Two frames 8'h11, 8'h22 back-to-back with no read → `data_out`=8'h11, `overrun`=1. `read_byte` clears both.
- Commit of 8'h22 coincident with `read_byte` of 8'h11 → `data_out`=8'h22, `byte_ready`=1, `overrun`=0.
- Assert `reset` low during data bit 4 of 8'hFF → all outputs at reset values, then a fresh 8'h5A after release is received intact.
